mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one `memory` instance between two requesters: port 0 is instruction fetch (read-only), port 1 is the data/load-store path (read/write).
- Sits between `fetch` (and the future LSU) and `memory`. It replaces the direct fetch-to-memory wiring.
- Only one transaction is in flight at a time.
- Round-robin arbitration applies when both ports request in the same cycle; the response is buffered and returned only to the owning port.

Parameters:
ADDRESS_WIDTH, `ADDRESS_WIDTH, memory address width
DATA_WIDTH, `DATA_WIDTH, memory data word width
CMD_WIDTH, 2, width of memory command field; encodings `MEM_CMD_READ / `MEM_CMD_WRITE from header.v, passed through opaquely

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
i_p0_valid  input  1  fetch request valid; address held stable until accepted
i_p0_addr  input  ADDRESS_WIDTH  fetch read address
o_p0_ready  output  1  fetch request accepted this cycle
o_p0_res_valid  output  1  fetch read data valid
o_p0_data  output  DATA_WIDTH  fetch read data
i_p0_res_ready  input  1  fetch consumes response
i_p1_valid  input  1  data-port request valid; fields held until accepted
i_p1_addr  input  ADDRESS_WIDTH  data-port address
i_p1_cmd  input  CMD_WIDTH  data-port command
i_p1_data  input  DATA_WIDTH  data-port write data
o_p1_ready  output  1  data-port request accepted this cycle
o_p1_res_valid  output  1  data-port response valid (read data or write ack)
o_p1_data  output  DATA_WIDTH  data-port read data (don't-care for writes)
i_p1_res_ready  input  1  data port consumes response
o_mem_valid  output  1  to memory i_valid
o_mem_addr  output  ADDRESS_WIDTH  to memory i_address
o_mem_cmd  output  CMD_WIDTH  to memory i_cmd
o_mem_data  output  DATA_WIDTH  to memory i_data
i_mem_ready  input  1  from memory o_ready
i_mem_res_valid  input  1  from memory o_res_valid
i_mem_data  input  DATA_WIDTH  from memory o_data
o_mem_res_ready  output  1  to memory i_res_ready
o_owner  output  1  port owning current transaction (0/1)
o_busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset: state=IDLE, rr pointer=0 (port 0 favoured), owner=0, all valid/ready outputs 0, o_mem_addr/cmd/data/o_pN_data 0.
- Grant in IDLE:
  - One valid port: grant it.
  - Both valid: grant the port equal to the rr pointer.
  - o_pN_ready=1 combinationally in IDLE for the granted port only, the same cycle.
- Accept cycle:
  - Latch addr/cmd/data and owner. Port 0 cmd is forced to `MEM_CMD_READ and data to 0.
  - Set rr pointer to ~granted.
  - Next state ISSUE.
- ISSUE:
  - o_mem_valid=1 with latched fields, held stable.
  - On i_mem_ready=1 the command is taken; go to WAIT.
  - Minimum latency: request accept at cycle N, o_mem_valid at N+1.
- WAIT:
  - o_mem_res_ready=1 (it is 0 in all other states).
  - On i_mem_res_valid, latch i_mem_data and go to RESP.
  - Memory returns one response per command, for reads and writes.
  - If i_mem_res_valid coincides with the ISSUE handshake cycle, ignore it. Memory must not respond in the same cycle it accepts.
- RESP:
  - o_pOwner_res_valid=1 with latched data; the other port's res_valid stays 0.
  - On i_pOwner_res_ready, go to IDLE. A new grant is possible on the next cycle, not the same cycle.
  - Back-to-back turnaround: at least 1 idle cycle between transactions.
- i_pN_valid is ignored outside IDLE; o_pN_ready is 0 outside IDLE.
- Fairness: under continuous requests from both ports, grants alternate strictly 0,1,0,1,...
- Async reset mid-transaction: return to IDLE at once and drop every valid output. Any in-flight memory response is discarded. Memory shares reset, so no orphan response may arrive afterwards.
- No arithmetic; the address passes through unmodified.

Test Plan:
- Reset then p0 only, addr 0x0, memory preloaded 0xDEADBEEF:
  - o_p0_ready pulses 1 cycle; o_mem_valid next cycle with addr 0x0, cmd READ.
  - Then o_p0_res_valid with data 0xDEADBEEF; o_p1_res_valid stays 0.
- p1 write 0x10←0x12345678, then p1 read 0x10 → write ack on o_p1_res_valid, read returns 0x12345678, o_mem_cmd matches each request.
- p0 and p1 both valid continuously from reset, addrs 0x4/0x20 → grant order p0,p1,p0,p1; o_owner toggles; each response goes only to its owner.
- Hold i_mem_ready=0 for 5 cycles in ISSUE → o_mem_valid and o_mem_addr stay stable, no o_pN_ready pulses; proceeds when ready rises.
- Hold i_p0_res_ready=0 for 4 cycles in RESP → o_p0_res_valid and data stay held; p1 request waiting is not granted until after release plus 1 cycle.
- Assert reset during WAIT → all valid/ready outputs 0 immediately; after release the first grant goes to p0 and no stale response is delivered.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the shared memory.
// Signal names and directions are from the arbiter's point of view.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CMD_WIDTH     = 2
);
    // fetch port (read-only)
    logic                     i_p0_valid;
    logic [ADDRESS_WIDTH-1:0] i_p0_addr;
    logic                     o_p0_ready;
    logic                     o_p0_res_valid;
    logic [DATA_WIDTH-1:0]    o_p0_data;
    logic                     i_p0_res_ready;

    // data port (read/write)
    logic                     i_p1_valid;
    logic [ADDRESS_WIDTH-1:0] i_p1_addr;
    logic [CMD_WIDTH-1:0]     i_p1_cmd;
    logic [DATA_WIDTH-1:0]    i_p1_data;
    logic                     o_p1_ready;
    logic                     o_p1_res_valid;
    logic [DATA_WIDTH-1:0]    o_p1_data;
    logic                     i_p1_res_ready;

    // memory side
    logic                     o_mem_valid;
    logic [ADDRESS_WIDTH-1:0] o_mem_addr;
    logic [CMD_WIDTH-1:0]     o_mem_cmd;
    logic [DATA_WIDTH-1:0]    o_mem_data;
    logic                     i_mem_ready;
    logic                     i_mem_res_valid;
    logic [DATA_WIDTH-1:0]    i_mem_data;
    logic                     o_mem_res_ready;

    // status
    logic                     o_owner;
    logic                     o_busy;

    modport slave (
        input  i_p0_valid, i_p0_addr, i_p0_res_ready,
        input  i_p1_valid, i_p1_addr, i_p1_cmd, i_p1_data, i_p1_res_ready,
        input  i_mem_ready, i_mem_res_valid, i_mem_data,
        output o_p0_ready, o_p0_res_valid, o_p0_data,
        output o_p1_ready, o_p1_res_valid, o_p1_data,
        output o_mem_valid, o_mem_addr, o_mem_cmd, o_mem_data, o_mem_res_ready,
        output o_owner, o_busy
    );

    modport master (
        output i_p0_valid, i_p0_addr, i_p0_res_ready,
        output i_p1_valid, i_p1_addr, i_p1_cmd, i_p1_data, i_p1_res_ready,
        output i_mem_ready, i_mem_res_valid, i_mem_data,
        input  o_p0_ready, o_p0_res_valid, o_p0_data,
        input  o_p1_ready, o_p1_res_valid, o_p1_data,
        input  o_mem_valid, o_mem_addr, o_mem_cmd, o_mem_data, o_mem_res_ready,
        input  o_owner, o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory: one transaction in flight,
// response buffered and returned only to the port that issued the request.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned          ADDRESS_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          CMD_WIDTH     = 2,
    parameter logic [CMD_WIDTH-1:0] MEM_CMD_READ  = CMD_WIDTH'(0)
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [CMD_WIDTH-1:0]     cmd;
        logic [DATA_WIDTH-1:0]    data;
    } req_t;

    logic [1:0]            state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  owner_q, owner_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic any_req_c;
    logic grant_c;
    logic p0_ready_c, p1_ready_c;
    logic p0_res_valid_c, p1_res_valid_c;
    logic mem_valid_c, mem_res_ready_c;
    logic owner_res_ready_c;

    // Port choice: a lone requester wins; on contention the rr pointer decides.
    always_comb begin
        any_req_c = bus.i_p0_valid | bus.i_p1_valid;
        if (bus.i_p0_valid && bus.i_p1_valid) begin
            grant_c = rr_q;
        end else begin
            grant_c = bus.i_p1_valid;
        end
        owner_res_ready_c = owner_q ? bus.i_p1_res_ready : bus.i_p0_res_ready;
    end

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        owner_d         = owner_q;
        req_d           = req_q;
        rdata_d         = rdata_q;
        p0_ready_c      = 1'b0;
        p1_ready_c      = 1'b0;
        p0_res_valid_c  = 1'b0;
        p1_res_valid_c  = 1'b0;
        mem_valid_c     = 1'b0;
        mem_res_ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                // reset gating keeps ready low while reset is held with a valid present
                p0_ready_c = any_req_c & ~grant_c & ~reset;
                p1_ready_c = any_req_c &  grant_c & ~reset;
                if (any_req_c) begin
                    state_d = S_ISSUE;
                    owner_d = grant_c;
                    rr_d    = ~grant_c;
                    if (grant_c) begin
                        req_d = '{addr: bus.i_p1_addr, cmd: bus.i_p1_cmd, data: bus.i_p1_data};
                    end else begin
                        req_d = '{addr: bus.i_p0_addr, cmd: MEM_CMD_READ, data: DATA_WIDTH'(0)};
                    end
                end
            end
            S_ISSUE: begin
                mem_valid_c = 1'b1;
                if (bus.i_mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_res_ready_c = 1'b1;
                if (bus.i_mem_res_valid) begin
                    rdata_d = bus.i_mem_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                p0_res_valid_c = ~owner_q;
                p1_res_valid_c =  owner_q;
                if (owner_res_ready_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.o_p0_ready      = p0_ready_c;
    assign bus.o_p1_ready      = p1_ready_c;
    assign bus.o_p0_res_valid  = p0_res_valid_c;
    assign bus.o_p1_res_valid  = p1_res_valid_c;
    assign bus.o_p0_data       = rdata_q;
    assign bus.o_p1_data       = rdata_q;
    assign bus.o_mem_valid     = mem_valid_c;
    assign bus.o_mem_addr      = req_q.addr;
    assign bus.o_mem_cmd       = req_q.cmd;
    assign bus.o_mem_data      = req_q.data;
    assign bus.o_mem_res_ready = mem_res_ready_c;
    assign bus.o_owner         = owner_q;
    assign bus.o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the memory by hand.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;
    localparam logic [1:0]  RD = 2'b00;
    localparam logic [1:0]  WR = 2'b01;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CMD_WIDTH(CW)) bus ();

    mem_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .MEM_CMD_READ(RD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Runs one transaction from IDLE with the requesting valids already driven.
    task automatic serve(input logic own, input logic [31:0] a, input logic [1:0] c,
                         input logic [31:0] wd, input logic [31:0] rd);
        #1;
        chk("grant_p0", 64'(bus.o_p0_ready), 64'(!own));
        chk("grant_p1", 64'(bus.o_p1_ready), 64'(own));
        step(); #1;
        chk("issue_valid", 64'(bus.o_mem_valid), 64'(1));
        chk("issue_addr",  64'(bus.o_mem_addr),  64'(a));
        chk("issue_cmd",   64'(bus.o_mem_cmd),   64'(c));
        chk("issue_data",  64'(bus.o_mem_data),  64'(wd));
        chk("issue_owner", 64'(bus.o_owner),     64'(own));
        chk("issue_rdy0",  64'(bus.o_p0_ready),  64'(0));
        chk("issue_rdy1",  64'(bus.o_p1_ready),  64'(0));
        // a response in the accept cycle must be ignored
        bus.i_mem_res_valid = 1'b1;
        bus.i_mem_data      = 32'hBAD0_BAD0;
        step();
        bus.i_mem_res_valid = 1'b0;
        #1;
        chk("wait_resrdy", 64'(bus.o_mem_res_ready), 64'(1));
        chk("wait_mvalid", 64'(bus.o_mem_valid),     64'(0));
        chk("wait_rv0",    64'(bus.o_p0_res_valid),  64'(0));
        chk("wait_rv1",    64'(bus.o_p1_res_valid),  64'(0));
        bus.i_mem_res_valid = 1'b1;
        bus.i_mem_data      = rd;
        step();
        bus.i_mem_res_valid = 1'b0;
        #1;
        chk("resp_rv0",   64'(bus.o_p0_res_valid), 64'(!own));
        chk("resp_rv1",   64'(bus.o_p1_res_valid), 64'(own));
        chk("resp_data",  64'(own ? bus.o_p1_data : bus.o_p0_data), 64'(rd));
        chk("resp_resrdy", 64'(bus.o_mem_res_ready), 64'(0));
        if (own) bus.i_p1_res_ready = 1'b1;
        else     bus.i_p0_res_ready = 1'b1;
        step();
        bus.i_p0_res_ready = 1'b0;
        bus.i_p1_res_ready = 1'b0;
        chk("done_busy", 64'(bus.o_busy),         64'(0));
        chk("done_rv0",  64'(bus.o_p0_res_valid), 64'(0));
        chk("done_rv1",  64'(bus.o_p1_res_valid), 64'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.i_p0_valid = 1'b0; bus.i_p0_addr = '0; bus.i_p0_res_ready = 1'b0;
        bus.i_p1_valid = 1'b0; bus.i_p1_addr = '0; bus.i_p1_cmd = RD;
        bus.i_p1_data  = '0;   bus.i_p1_res_ready = 1'b0;
        bus.i_mem_ready = 1'b1; bus.i_mem_res_valid = 1'b0; bus.i_mem_data = '0;

        // reset state
        step(); step(); #1;
        chk("rst_busy",   64'(bus.o_busy),          64'(0));
        chk("rst_owner",  64'(bus.o_owner),         64'(0));
        chk("rst_mvalid", 64'(bus.o_mem_valid),     64'(0));
        chk("rst_mrr",    64'(bus.o_mem_res_ready), 64'(0));
        chk("rst_addr",   64'(bus.o_mem_addr),      64'(0));
        chk("rst_data0",  64'(bus.o_p0_data),       64'(0));
        chk("rst_rdy0",   64'(bus.o_p0_ready),      64'(0));
        reset = 1'b0;
        step();

        // fetch read of 0x0
        bus.i_p0_valid = 1'b1; bus.i_p0_addr = 32'h0;
        serve(1'b0, 32'h0, RD, 32'h0, 32'hDEAD_BEEF);
        bus.i_p0_valid = 1'b0;

        // data port write then read-back
        bus.i_p1_valid = 1'b1; bus.i_p1_addr = 32'h10; bus.i_p1_cmd = WR; bus.i_p1_data = 32'h1234_5678;
        serve(1'b1, 32'h10, WR, 32'h1234_5678, 32'h0);
        bus.i_p1_cmd = RD; bus.i_p1_data = 32'h0;
        serve(1'b1, 32'h10, RD, 32'h0, 32'h1234_5678);
        bus.i_p1_valid = 1'b0;

        // continuous contention from reset: strict alternation, p0 fields forced to read/0
        reset = 1'b1; step(); reset = 1'b0; step();
        bus.i_p0_valid = 1'b1; bus.i_p0_addr = 32'h4;
        bus.i_p1_valid = 1'b1; bus.i_p1_addr = 32'h20; bus.i_p1_cmd = WR; bus.i_p1_data = 32'h55;
        serve(1'b0, 32'h4,  RD, 32'h0,  32'hA0);
        serve(1'b1, 32'h20, WR, 32'h55, 32'h0);
        serve(1'b0, 32'h4,  RD, 32'h0,  32'hA1);
        serve(1'b1, 32'h20, WR, 32'h55, 32'h0);
        bus.i_p0_valid = 1'b0; bus.i_p1_valid = 1'b0;

        // memory back-pressure in ISSUE, then held response in RESP with p1 waiting
        bus.i_mem_ready = 1'b0;
        bus.i_p0_valid = 1'b1; bus.i_p0_addr = 32'h8;
        bus.i_p1_valid = 1'b1; bus.i_p1_addr = 32'h40; bus.i_p1_cmd = RD; bus.i_p1_data = 32'h0;
        #1;
        chk("bp_grant0", 64'(bus.o_p0_ready), 64'(1));
        chk("bp_grant1", 64'(bus.o_p1_ready), 64'(0));
        step();
        bus.i_p0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_mvalid", 64'(bus.o_mem_valid), 64'(1));
            chk("bp_addr",   64'(bus.o_mem_addr),  64'(32'h8));
            chk("bp_rdy0",   64'(bus.o_p0_ready),  64'(0));
            chk("bp_rdy1",   64'(bus.o_p1_ready),  64'(0));
            step();
        end
        bus.i_mem_ready = 1'b1;
        #1;
        chk("bp_mvalid_last", 64'(bus.o_mem_valid), 64'(1));
        step(); #1;
        chk("bp_wait", 64'(bus.o_mem_res_ready), 64'(1));
        bus.i_mem_res_valid = 1'b1; bus.i_mem_data = 32'hDEAD_C0DE;
        step();
        bus.i_mem_res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_rv0",  64'(bus.o_p0_res_valid), 64'(1));
            chk("hold_data", 64'(bus.o_p0_data),      64'(32'hDEAD_C0DE));
            chk("hold_rv1",  64'(bus.o_p1_res_valid), 64'(0));
            chk("hold_rdy1", 64'(bus.o_p1_ready),     64'(0));
            step();
        end
        bus.i_p0_res_ready = 1'b1;
        #1;
        chk("rel_rdy1", 64'(bus.o_p1_ready), 64'(0));
        step();
        bus.i_p0_res_ready = 1'b0;
        serve(1'b1, 32'h40, RD, 32'h0, 32'h4444);
        bus.i_p1_valid = 1'b0;

        // reset while waiting for the memory response
        bus.i_p0_valid = 1'b1; bus.i_p0_addr = 32'hC;
        step();
        bus.i_p0_valid = 1'b0;
        step(); #1;
        chk("pre_rst_wait", 64'(bus.o_mem_res_ready), 64'(1));
        reset = 1'b1;
        bus.i_p0_valid = 1'b1; bus.i_p0_addr = 32'h14;
        bus.i_p1_valid = 1'b1; bus.i_p1_addr = 32'h40;
        #1;
        chk("mid_rst_mrr",  64'(bus.o_mem_res_ready), 64'(0));
        chk("mid_rst_mv",   64'(bus.o_mem_valid),     64'(0));
        chk("mid_rst_busy", 64'(bus.o_busy),          64'(0));
        chk("mid_rst_rdy0", 64'(bus.o_p0_ready),      64'(0));
        chk("mid_rst_rdy1", 64'(bus.o_p1_ready),      64'(0));
        chk("mid_rst_rv0",  64'(bus.o_p0_res_valid),  64'(0));
        step();
        reset = 1'b0;
        serve(1'b0, 32'h14, RD, 32'h0, 32'h77);
        bus.i_p0_valid = 1'b0;
        serve(1'b1, 32'h40, RD, 32'h0, 32'h88);
        bus.i_p1_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
